// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a single-entry holding register.
// rdy rises 1 clk after the mid-stop-bit tick; rdy_clr acknowledges, sticky flags clear with it.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_clk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Reset asserts asynchronously but releases only after two clean clk edges.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    logic [1:0] rx_sync_q;
    logic       rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
        end
    end

    assign rx_s = rx_sync_q[1];

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   rdy_q;
    logic                   frame_err_q;
    logic                   overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // The acknowledge acts every clk; a completion later in this block overrides it.
            if (rdy_clr) begin
                rdy_q       <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            if (rx_clk_en) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end
                    START: begin
                        if (cnt_q == CNT_HALF) begin
                            if (!rx_s) begin
                                state_q   <= DATA;
                                cnt_q     <= '0;
                                bit_idx_q <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            cnt_q   <= '0;
                            if (bit_idx_q == BIT_LAST) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + BW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    STOP: begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            if (rx_s) begin
                                data_q <= shift_q;
                                rdy_q  <= 1'b1;
                                if (rdy_q && !rdy_clr) begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames driven with rx_clk_en every 4 clk (64 clk per bit), scoreboard-checked.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_clk_en = 1'b0;
    logic       rx = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;

    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   div = 0;
    event frame_start;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_clk_en (rx_clk_en),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .data      (data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div = (div + 1) % 4;
        rx_clk_en = (div == 0);
    end

    // Frame starts just after the negedge that raises rx_clk_en, so the mid-stop
    // sampling tick is the posedge following negedge 612 of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at);
        logic [9:0] fr;
        int n;
        fr = {stop, b, 1'b0};
        n = 0;
        do begin
            @(negedge clk);
            #1;
        end while (!rx_clk_en);
        ->frame_start;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (64) begin
                @(negedge clk);
                #1;
                n++;
                rdy_clr = (n == clr_at);
            end
        end
        rx = 1'b1;
        rdy_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        #1 rdy_clr = 1'b1;
        @(negedge clk);
        #1 rdy_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", {data, rdy, frame_err, overrun}, 11'h0);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        sb.push_back('{8'hA5, 1'b1, 1'b0, 1'b0});
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                @(frame_start);
                repeat (612) @(negedge clk);
                #2;
                n_cmp++;
                if (rdy !== 1'b0) begin
                    n_err++;
                    $display("FAIL latency_early: rdy got %b want 0", rdy);
                end
                @(negedge clk);
                #2;
                n_cmp++;
                if (rdy !== 1'b1) begin
                    n_err++;
                    $display("FAIL latency_edge: rdy got %b want 1", rdy);
                end
            end
        join
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL byte_a5: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
        sb.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
        pulse_clr();
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL clr_a5: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b1, -1);
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL b2b_first: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
        sb.push_back('{8'h7E, 1'b1, 1'b0, 1'b1});
        send_frame(8'h7E, 1'b1, -1);
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL b2b_overrun: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
    endtask

    task automatic test_frame_err();
        pulse_clr();
        sb.push_back('{8'h7E, 1'b0, 1'b1, 1'b0});
        send_frame(8'h55, 1'b0, -1);
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL ferr_55: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
        repeat (64) @(negedge clk);
        sb.push_back('{8'h0F, 1'b1, 1'b1, 1'b0});
        send_frame(8'h0F, 1'b1, -1);
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL ferr_sticky: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
        sb.push_back('{8'h0F, 1'b0, 1'b0, 1'b0});
        pulse_clr();
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL ferr_clr: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        #1 rx = 1'b0;
        repeat (20) @(negedge clk);
        #1 rx = 1'b1;
        repeat (100) @(negedge clk);
        #2;
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== {8'h0F, 3'b000}) begin
            n_err++;
            $display("FAIL glitch_idle: got %h want %h", {data, rdy, frame_err, overrun}, {8'h0F, 3'b000});
        end
        sb.push_back('{8'h81, 1'b1, 1'b0, 1'b0});
        send_frame(8'h81, 1'b1, -1);
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL glitch_81: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
    endtask

    task automatic test_mid_reset();
        fork
            send_frame(8'hFF, 1'b1, -1);
            begin
                @(frame_start);
                repeat (5 * 64 + 32) @(negedge clk);
                #2 reset = 1'b1;
                #1;
                n_cmp++;
                if ({data, rdy, frame_err, overrun} !== 11'h0) begin
                    n_err++;
                    $display("FAIL reset_mid: got %h want %h", {data, rdy, frame_err, overrun}, 11'h0);
                end
                repeat (10) @(negedge clk);
                #2 reset = 1'b0;
            end
        join
        repeat (100) @(negedge clk);
        #2;
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_after: got %h want %h", {data, rdy, frame_err, overrun}, 11'h0);
        end
        sb.push_back('{8'h12, 1'b1, 1'b0, 1'b0});
        send_frame(8'h12, 1'b1, -1);
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL reset_12: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
    endtask

    task automatic test_clr_collision();
        sb.push_back('{8'h99, 1'b1, 1'b0, 1'b0});
        send_frame(8'h99, 1'b1, 612);
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL clr_vs_done: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
        sb.push_back('{8'h99, 1'b0, 1'b1, 1'b0});
        send_frame(8'h55, 1'b0, 612);
        e = sb.pop_front();
        n_cmp++;
        if ({data, rdy, frame_err, overrun} !== e) begin
            n_err++;
            $display("FAIL clr_vs_ferr: got %h want %h", {data, rdy, frame_err, overrun}, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        test_clr_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
